// File: rtl/stream_concat_pkg.sv
// stream_concat_pkg: shared constants and lane-width helpers for stream_concat_hs.
package stream_concat_pkg;

    localparam int MAX_PORTS = 4;
    localparam int SKEW_W    = 8;

    // widths holds one 32-bit width per lane, lane 0 in the low word; sums lanes 0..n-1
    function automatic int sum_width(input logic [MAX_PORTS*32-1:0] widths, input int n);
        int s;
        s = 0;
        for (int i = 0; i < MAX_PORTS; i++)
            if (i < n) s += int'(widths[32*i +: 32]);
        return s;
    endfunction

endpackage

// File: rtl/concat_lane_hold.sv
// concat_lane_hold: one-deep holding register for a single input lane, with its ready logic.
module concat_lane_hold #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    input  logic             vld_i,
    input  logic             join_i,
    output logic             rdy_o,
    output logic             hold_v_o,
    output logic [WIDTH-1:0] data_o
);

    logic             hold_v_q, hold_v_d, load;
    logic [WIDTH-1:0] data_q, data_d;

    assign rdy_o    = ~hold_v_q | join_i;
    assign load     = vld_i & rdy_o;
    assign hold_v_o = hold_v_q;
    assign data_o   = data_q;

    always_comb begin
        hold_v_d = load ? 1'b1 : join_i ? 1'b0 : hold_v_q;
        data_d   = load ? data_i : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_v_q <= 1'b0;
            data_q   <= '0;
        end else begin
            hold_v_q <= hold_v_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: rtl/stream_concat_hs.sv
// stream_concat_hs: joins up to four valid/ready lanes into one registered word,
// with lane-skew detection and a downstream beat counter.
module stream_concat_hs
    import stream_concat_pkg::*;
#(
    parameter int PORT_NUM   = 2,
    parameter int IN_WIDTH_0 = 1,
    parameter int IN_WIDTH_1 = 5,
    parameter int IN_WIDTH_2 = 1,
    parameter int IN_WIDTH_3 = 1,
    parameter int OUT_WIDTH  = 6,
    parameter int MAX_SKEW   = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_WIDTH_0-1:0] In0,
    input  logic [IN_WIDTH_1-1:0] In1,
    input  logic [IN_WIDTH_2-1:0] In2,
    input  logic [IN_WIDTH_3-1:0] In3,
    input  logic                  In0_vld,
    input  logic                  In1_vld,
    input  logic                  In2_vld,
    input  logic                  In3_vld,
    output logic                  In0_rdy,
    output logic                  In1_rdy,
    output logic                  In2_rdy,
    output logic                  In3_rdy,
    output logic [OUT_WIDTH-1:0]  Dout,
    output logic                  Dout_vld,
    input  logic                  Dout_rdy,
    input  logic                  Clr_err,
    output logic                  Skew_err,
    output logic [CNT_W-1:0]      Beat_cnt
);

    localparam logic [MAX_PORTS*32-1:0] WIDTHS =
        {32'(IN_WIDTH_3), 32'(IN_WIDTH_2), 32'(IN_WIDTH_1), 32'(IN_WIDTH_0)};
    localparam int TOTAL_W = sum_width(WIDTHS, MAX_PORTS);
    localparam logic [SKEW_W-1:0] SKEW_MAX = SKEW_W'(MAX_SKEW);

    logic [TOTAL_W-1:0]   lane_in, lane_hold;
    logic [MAX_PORTS-1:0] in_vld, in_rdy, hold_v;
    logic                 join_w, out_free, partial, unused_ok;
    logic [OUT_WIDTH-1:0] dout_q, dout_d;
    logic                 dout_vld_q, dout_vld_d, skew_err_q, skew_err_d;
    logic [SKEW_W-1:0]    skew_cnt_q, skew_cnt_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;

    if (PORT_NUM < 1 || PORT_NUM > MAX_PORTS || MAX_SKEW < 1 || MAX_SKEW > 255 ||
        OUT_WIDTH != sum_width(WIDTHS, PORT_NUM)) begin : g_bad_cfg
        $error("stream_concat_hs: invalid PORT_NUM/MAX_SKEW or OUT_WIDTH != sum of active lane widths");
    end

    assign lane_in = {In3, In2, In1, In0};
    assign in_vld  = {In3_vld, In2_vld, In1_vld, In0_vld};
    assign {In3_rdy, In2_rdy, In1_rdy, In0_rdy} = in_rdy;
    assign unused_ok = ^{lane_in, in_vld, lane_hold};

    // lanes share one packed bus so lane k sits at the sum of the widths below it
    for (genvar k = 0; k < MAX_PORTS; k++) begin : g_lane
        localparam int W   = int'(WIDTHS[32*k +: 32]);
        localparam int OFF = sum_width(WIDTHS, k);
        if (k < PORT_NUM) begin : g_on
            concat_lane_hold #(.WIDTH(W)) u_hold (
                .clk      (clk),
                .rst      (rst),
                .data_i   (lane_in[OFF +: W]),
                .vld_i    (in_vld[k]),
                .join_i   (join_w),
                .rdy_o    (in_rdy[k]),
                .hold_v_o (hold_v[k]),
                .data_o   (lane_hold[OFF +: W])
            );
        end else begin : g_off
            assign in_rdy[k]           = 1'b0;
            assign hold_v[k]           = 1'b0;
            assign lane_hold[OFF +: W] = '0;
        end
    end

    assign out_free = ~dout_vld_q | Dout_rdy;
    assign join_w   = &hold_v[PORT_NUM-1:0] & out_free;
    assign partial  = |hold_v & ~&hold_v[PORT_NUM-1:0];

    always_comb begin
        dout_d     = join_w ? lane_hold[OUT_WIDTH-1:0] : dout_q;
        dout_vld_d = join_w | (dout_vld_q & ~Dout_rdy);
        skew_cnt_d = ~partial ? '0 : (skew_cnt_q == SKEW_MAX) ? skew_cnt_q : skew_cnt_q + 1'b1;
        skew_err_d = (skew_cnt_d == SKEW_MAX) | (skew_err_q & ~Clr_err);
        beat_cnt_d = beat_cnt_q + CNT_W'(dout_vld_q & Dout_rdy);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            skew_cnt_q <= '0;
            skew_err_q <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            skew_cnt_q <= skew_cnt_d;
            skew_err_q <= skew_err_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign Dout     = dout_q;
    assign Dout_vld = dout_vld_q;
    assign Skew_err = skew_err_q;
    assign Beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_stream_concat_hs.sv
// tb_stream_concat_hs: queue-based reference model and scoreboard around stream_concat_hs
// (two lanes 1+5 bits, MAX_SKEW=4, 4-bit beat counter), directed cases then random traffic.
module tb_stream_concat_hs;

    localparam int MAXS = 4;
    localparam int CW   = 4;

    logic       clk = 0, rst = 1;
    logic       In0 = 0, In2 = 0, In3 = 0;
    logic [4:0] In1 = 0;
    logic       In0_vld = 0, In1_vld = 0, In2_vld = 0, In3_vld = 0;
    logic       In0_rdy, In1_rdy, In2_rdy, In3_rdy;
    logic [5:0] Dout;
    logic       Dout_vld, Dout_rdy = 1, Clr_err = 0, Skew_err;
    logic [CW-1:0] Beat_cnt;

    int n_cmp = 0, n_bad = 0;
    bit armed = 0;

    stream_concat_hs #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .In0(In0), .In1(In1), .In2(In2), .In3(In3),
        .In0_vld(In0_vld), .In1_vld(In1_vld), .In2_vld(In2_vld), .In3_vld(In3_vld),
        .In0_rdy(In0_rdy), .In1_rdy(In1_rdy), .In2_rdy(In2_rdy), .In3_rdy(In3_rdy),
        .Dout(Dout), .Dout_vld(Dout_vld), .Dout_rdy(Dout_rdy),
        .Clr_err(Clr_err), .Skew_err(Skew_err), .Beat_cnt(Beat_cnt)
    );

    always #5 clk = ~clk;

    function void chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: each lane is a queue of at most one pending word, the output a single slot.
    logic       m_q0[$];
    logic [4:0] m_q1[$];
    logic       s0[$];
    logic [4:0] s1[$];
    bit         m_ov = 0, m_err = 0;
    logic [5:0] m_dout = 0;
    int         m_run = 0, m_beats = 0;

    always @(negedge clk) begin
        bit full, jn, e0, e1, part;
        logic       b0;
        logic [4:0] b1;
        full = m_q0.size() != 0 && m_q1.size() != 0;
        jn   = full && (!m_ov || Dout_rdy);
        e0   = m_q0.size() == 0 || jn;
        e1   = m_q1.size() == 0 || jn;
        part = (m_q0.size() != 0) != (m_q1.size() != 0);
        if (armed) begin
            chk("rdy0", int'(In0_rdy), int'(e0));
            chk("rdy1", int'(In1_rdy), int'(e1));
            chk("rdy2_off", int'(In2_rdy), 0);
            chk("rdy3_off", int'(In3_rdy), 0);
            chk("dout_vld", int'(Dout_vld), int'(m_ov));
            chk("dout", int'(Dout), int'(m_dout));
            chk("skew_err", int'(Skew_err), int'(m_err));
            chk("beat_cnt", int'(Beat_cnt), m_beats % (1 << CW));
            if (!rst && Dout_vld && Dout_rdy) begin
                chk("sb_avail", int'(s0.size() != 0 && s1.size() != 0), 1);
                if (s0.size() != 0 && s1.size() != 0) begin
                    b0 = s0.pop_front();
                    b1 = s1.pop_front();
                    chk("sb_word", int'(Dout), int'({b1, b0}));
                end
            end
        end
        if (rst) begin
            s0.delete(); s1.delete(); m_q0.delete(); m_q1.delete();
            m_ov = 0; m_err = 0; m_dout = 0; m_run = 0; m_beats = 0;
            armed = 1;
        end else begin
            if (In0_vld && In0_rdy) s0.push_back(In0);
            if (In1_vld && In1_rdy) s1.push_back(In1);
            if (m_ov && Dout_rdy) m_beats++;
            m_run = part ? m_run + 1 : 0;
            m_err = (part && m_run >= MAXS) || (m_err && !Clr_err);
            if (jn) begin
                b0 = m_q0.pop_front();
                b1 = m_q1.pop_front();
                m_dout = {b1, b0};
                m_ov = 1;
            end else if (Dout_rdy) m_ov = 0;
            if (In0_vld && e0) m_q0.push_back(In0);
            if (In1_vld && e1) m_q1.push_back(In1);
        end
    end

    task tick();
        @(posedge clk);
        #1;
    endtask

    // Random traffic that keeps each lane's word and valid stable until it is accepted.
    task step(input int p0, input int p1, input int pr);
        bit h0, h1;
        #1;
        h0 = In0_vld && In0_rdy;
        h1 = In1_vld && In1_rdy;
        @(posedge clk);
        #1;
        if (h0 || !In0_vld) begin In0_vld = $urandom_range(0, 99) < p0; In0 = 1'($urandom); end
        if (h1 || !In1_vld) begin In1_vld = $urandom_range(0, 99) < p1; In1 = 5'($urandom); end
        Dout_rdy = $urandom_range(0, 99) < pr;
        Clr_err  = $urandom_range(0, 63) == 0;
    endtask

    initial begin
        repeat (3) tick();
        rst = 0;
        chk("reset_vld", int'(Dout_vld), 0);
        chk("reset_dout", int'(Dout), 0);
        chk("reset_err", int'(Skew_err), 0);
        chk("reset_beat", int'(Beat_cnt), 0);

        // aligned beat: {0A,1} appears two cycles later
        In0 = 1; In1 = 5'h0A; In0_vld = 1; In1_vld = 1;
        tick(); In0_vld = 0; In1_vld = 0;
        tick();
        chk("t1_vld", int'(Dout_vld), 1);
        chk("t1_dout", int'(Dout), 'h15);
        tick();
        chk("t1_beat", int'(Beat_cnt), 1);
        chk("t1_vld_off", int'(Dout_vld), 0);

        // three cycles of skew: no output until lane 1 arrives, no error
        In0 = 0; In0_vld = 1;
        tick(); In0_vld = 0;
        tick(); tick();
        In1 = 5'h13; In1_vld = 1;
        tick(); In1_vld = 0;
        chk("t2_wait", int'(Dout_vld), 0);
        tick();
        chk("t2_vld", int'(Dout_vld), 1);
        chk("t2_dout", int'(Dout), 'h26);
        chk("t2_no_err", int'(Skew_err), 0);
        tick(); tick();

        // six cycles of skew: error after the fourth partial cycle, sticky until cleared
        In0 = 1; In0_vld = 1;
        tick(); In0_vld = 0;
        tick(); tick(); tick();
        chk("t3_err_pre", int'(Skew_err), 0);
        tick();
        chk("t3_err_set", int'(Skew_err), 1);
        tick();
        In1 = 5'h1F; In1_vld = 1;
        tick(); In1_vld = 0;
        tick(); tick();
        chk("t3_err_sticky", int'(Skew_err), 1);
        Clr_err = 1;
        tick(); Clr_err = 0;
        chk("t3_err_clr", int'(Skew_err), 0);

        // streaming with a five-cycle downstream stall
        repeat (6) step(100, 100, 100);
        repeat (5) step(100, 100, 0);
        chk("t4_rdy0_stall", int'(In0_rdy), 0);
        chk("t4_rdy1_stall", int'(In1_rdy), 0);
        chk("t4_vld_stall", int'(Dout_vld), 1);
        repeat (10) step(100, 100, 100);
        In0_vld = 0; In1_vld = 0; Dout_rdy = 1; Clr_err = 0;
        repeat (4) tick();

        // 17 accepted beats wrap a 4-bit counter to 1
        rst = 1; tick(); rst = 0;
        for (int i = 0; i < 17; i++) begin
            In0 = 1'(i); In1 = 5'(i); In0_vld = 1; In1_vld = 1;
            tick();
        end
        In0_vld = 0; In1_vld = 0;
        repeat (4) tick();
        chk("t5_wrap", int'(Beat_cnt), 1);

        // reset with lane 0 held and an output beat pending
        Dout_rdy = 0; In0 = 1; In1 = 5'h05; In0_vld = 1; In1_vld = 1;
        tick(); In0_vld = 0; In1_vld = 0;
        tick(); In0 = 0; In0_vld = 1;
        tick(); In0_vld = 0;
        chk("t6_pre_vld", int'(Dout_vld), 1);
        chk("t6_pre_rdy1", int'(In1_rdy), 1);
        rst = 1;
        tick(); rst = 0; Dout_rdy = 1;
        chk("t6_vld", int'(Dout_vld), 0);
        chk("t6_dout", int'(Dout), 0);
        chk("t6_err", int'(Skew_err), 0);
        chk("t6_rdy0", int'(In0_rdy), 1);
        repeat (3) tick();
        chk("t6_no_beat", int'(Beat_cnt), 0);
        chk("t6_vld_after", int'(Dout_vld), 0);

        // random traffic with uneven lane rates and backpressure
        repeat (3000) step(80, 60, 70);
        In0_vld = 0; In1_vld = 0; Dout_rdy = 1; Clr_err = 0;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
